// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Owner and grant bit positions share one numbering so a one-hot grant maps directly onto an owner.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_LD  = 2'd0,
        OWN_ST  = 2'd1,
        OWN_EXT = 2'd2
    } owner_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    localparam int N_REQ   = 3;
    localparam int GNT_LD  = 0;
    localparam int GNT_ST  = 1;
    localparam int GNT_EXT = 2;

    // Write masks are active-low, so all ones means no byte is written.
    localparam logic [3:0] STRB_NO_WRITE = 4'b1111;

    function automatic owner_t grant_to_owner(input logic [N_REQ-1:0] grant);
        owner_t own;
        own = OWN_LD;
        if (grant[GNT_ST]) begin
            own = OWN_ST;
        end else if (grant[GNT_EXT]) begin
            own = OWN_EXT;
        end
        return own;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_prio.sv
// Fixed-priority selector (store > load > external) with an aging override for the external port.
// The grant depends only on the request valids and the starvation count, never on any address.
module dm_arb_prio
    import dm_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    input  logic             ld_valid,
    input  logic             ext_valid,
    input  logic             issue_ok,
    output logic [N_REQ-1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             starve_hit;
    logic             ext_hs;

    assign starve_hit = ext_valid && (cnt_reg == CNT_MAX);
    assign ext_hs     = issue_ok && grant[GNT_EXT];

    always_comb begin
        grant = '0;
        if (starve_hit) begin
            grant[GNT_EXT] = 1'b1;
        end else if (st_valid) begin
            grant[GNT_ST] = 1'b1;
        end else if (ld_valid) begin
            grant[GNT_LD] = 1'b1;
        end else if (ext_valid) begin
            grant[GNT_EXT] = 1'b1;
        end
    end

    // The count keeps aging while the memory stalls or an access is in flight.
    always_comb begin
        cnt_next = cnt_reg;
        if (!ext_valid || ext_hs) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-outstanding arbiter for the data-memory port: grants LSU store/load or the external
// requester, tracks the owner of the in-flight access and routes the response back to it.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_st_req_valid,
    output logic              lsu_st_req_ready,
    input  logic [3:0]        lsu_st_strb,
    input  logic [DATA_W-1:0] lsu_st_data,
    output logic              lsu_st_data_valid,
    input  logic              lsu_ld_req_valid,
    output logic              lsu_ld_req_ready,
    output logic              lsu_ld_data_valid,
    output logic [DATA_W-1:0] lsu_ld_data,
    input  logic              ext_req_valid,
    output logic              ext_req_ready,
    input  logic              ext_req_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [3:0]        ext_strb,
    output logic              ext_rsp_valid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [3:0]        dm_strb,
    input  logic              dm_rsp_valid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              err_spurious_rsp
);

    state_t           state_reg;
    owner_t           owner_reg;
    logic             err_reg;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready_vec;
    logic [N_REQ-1:0] rsp_hit;
    logic             can_issue;
    logic             any_req;
    logic             issue_ok;
    logic             req_hs;
    logic             rsp_live;

    // A response in flight frees the port in the same cycle, allowing back-to-back issue.
    assign can_issue = (state_reg == IDLE) || dm_rsp_valid;
    assign any_req   = lsu_st_req_valid || lsu_ld_req_valid || ext_req_valid;
    assign issue_ok  = can_issue && dm_req_ready;

    dm_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (lsu_st_req_valid),
        .ld_valid  (lsu_ld_req_valid),
        .ext_valid (ext_req_valid),
        .issue_ok  (issue_ok),
        .grant     (grant)
    );

    // Handshake outputs are forced low while reset is held, independent of the flop state.
    assign dm_req_valid     = rst_n && can_issue && any_req;
    assign req_hs           = dm_req_valid && dm_req_ready;
    assign ready_vec        = {N_REQ{rst_n && issue_ok}} & grant;
    assign lsu_st_req_ready = ready_vec[GNT_ST];
    assign lsu_ld_req_ready = ready_vec[GNT_LD];
    assign ext_req_ready    = ready_vec[GNT_EXT];

    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_strb  = STRB_NO_WRITE;
        if (grant[GNT_ST]) begin
            dm_we    = 1'b1;
            dm_addr  = lsu_addr;
            dm_wdata = lsu_st_data;
            dm_strb  = lsu_st_strb;
        end else if (grant[GNT_LD]) begin
            dm_addr  = lsu_addr;
        end else if (grant[GNT_EXT]) begin
            dm_we    = ext_req_we;
            dm_addr  = ext_addr;
            dm_wdata = ext_wdata;
            dm_strb  = ext_strb;
        end
    end

    // Responses seen in IDLE belong to nobody and are dropped here.
    assign rsp_live = rst_n && (state_reg == WAIT_RSP) && dm_rsp_valid;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_route
            assign rsp_hit[gi] = rsp_live && (owner_reg == owner_t'(gi));
        end
    endgenerate

    assign lsu_ld_data_valid = rsp_hit[GNT_LD];
    assign lsu_st_data_valid = rsp_hit[GNT_ST];
    assign ext_rsp_valid     = rsp_hit[GNT_EXT];
    assign lsu_ld_data       = dm_rdata;
    assign ext_rdata         = dm_rdata;
    assign err_spurious_rsp  = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= OWN_LD;
            err_reg   <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && dm_rsp_valid) begin
                err_reg <= 1'b1;
            end
            unique case (state_reg)
                IDLE: begin
                    if (req_hs) begin
                        state_reg <= WAIT_RSP;
                        owner_reg <= grant_to_owner(grant);
                    end
                end
                WAIT_RSP: begin
                    if (req_hs) begin
                        owner_reg <= grant_to_owner(grant);
                    end else if (dm_rsp_valid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed and randomized bench for dm_port_arbiter with a cycle-level reference model
// and a behavioural memory that answers a fixed number of cycles after each handshake.
module tb_dm_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] lsu_addr;
    logic          lsu_st_req_valid, lsu_st_req_ready;
    logic [3:0]    lsu_st_strb;
    logic [DW-1:0] lsu_st_data;
    logic          lsu_st_data_valid;
    logic          lsu_ld_req_valid, lsu_ld_req_ready;
    logic          lsu_ld_data_valid;
    logic [DW-1:0] lsu_ld_data;
    logic          ext_req_valid, ext_req_ready, ext_req_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [3:0]    ext_strb;
    logic          ext_rsp_valid;
    logic [DW-1:0] ext_rdata;
    logic          dm_req_valid, dm_req_ready, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [3:0]    dm_strb;
    logic          dm_rsp_valid;
    logic [DW-1:0] dm_rdata;
    logic          err_spurious_rsp;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_addr(lsu_addr),
        .lsu_st_req_valid(lsu_st_req_valid), .lsu_st_req_ready(lsu_st_req_ready),
        .lsu_st_strb(lsu_st_strb), .lsu_st_data(lsu_st_data), .lsu_st_data_valid(lsu_st_data_valid),
        .lsu_ld_req_valid(lsu_ld_req_valid), .lsu_ld_req_ready(lsu_ld_req_ready),
        .lsu_ld_data_valid(lsu_ld_data_valid), .lsu_ld_data(lsu_ld_data),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_we(ext_req_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_strb(ext_strb),
        .ext_rsp_valid(ext_rsp_valid), .ext_rdata(ext_rdata),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_strb(dm_strb),
        .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata), .err_spurious_rsp(err_spurious_rsp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: requester numbering 0 = load, 1 = store, 2 = external.
    bit          m_busy = 0;
    int          m_own = 0;
    int          m_starve = 0;
    bit          m_err = 0;
    int          cd = 0;
    int          lat = 1;
    bit          force_rsp = 0;
    bit          fix_rdata = 0;
    logic [31:0] rdata_fix = 32'hDEADBEEF;
    bit          keep_st = 0, keep_ld = 0, keep_ext = 0;
    int          cyc = 0;
    int          hs_own = -1;
    int          hs_cnt[3] = '{0, 0, 0};
    int          rsp_cnt[3] = '{0, 0, 0};
    int          last_hs_cyc[3] = '{0, 0, 0};
    int          last_rsp_cyc[3] = '{0, 0, 0};
    logic [31:0] last_ld_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int sel;
        bit can, expv, rsp_ok;
        dm_rsp_valid = force_rsp || (cd == 1);
        dm_rdata     = fix_rdata ? rdata_fix : $urandom;
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 0; m_starve = 0; m_err = 0;
        end
        sel = -1;
        if (ext_req_valid && m_starve >= SMAX) sel = 2;
        else if (lsu_st_req_valid)             sel = 1;
        else if (lsu_ld_req_valid)             sel = 0;
        else if (ext_req_valid)                sel = 2;
        can    = !m_busy || dm_rsp_valid;
        expv   = rst_n && can && (sel >= 0);
        rsp_ok = rst_n && m_busy && dm_rsp_valid;
        chk("dm_req_valid", dm_req_valid, expv);
        chk("st_ready", lsu_st_req_ready, expv && dm_req_ready && sel == 1);
        chk("ld_ready", lsu_ld_req_ready, expv && dm_req_ready && sel == 0);
        chk("ext_ready", ext_req_ready, expv && dm_req_ready && sel == 2);
        chk("ld_rsp", lsu_ld_data_valid, rsp_ok && m_own == 0);
        chk("st_rsp", lsu_st_data_valid, rsp_ok && m_own == 1);
        chk("ext_rsp", ext_rsp_valid, rsp_ok && m_own == 2);
        chk("err_flag", err_spurious_rsp, m_err);
        chk("ld_data", lsu_ld_data, dm_rdata);
        chk("ext_rdata", ext_rdata, dm_rdata);
        if (expv) begin
            case (sel)
                1: begin
                    chk("st_we", dm_we, 1'b1);
                    chk("st_addr", dm_addr, lsu_addr);
                    chk("st_wdata", dm_wdata, lsu_st_data);
                    chk("st_strb", dm_strb, lsu_st_strb);
                end
                0: begin
                    chk("ld_we", dm_we, 1'b0);
                    chk("ld_addr", dm_addr, lsu_addr);
                    chk("ld_strb", dm_strb, 4'b1111);
                end
                default: begin
                    chk("ext_we", dm_we, ext_req_we);
                    chk("ext_addr", dm_addr, ext_addr);
                    chk("ext_wdata", dm_wdata, ext_wdata);
                    chk("ext_strb", dm_strb, ext_strb);
                end
            endcase
        end
        if (rsp_ok) begin
            rsp_cnt[m_own]++;
            last_rsp_cyc[m_own] = cyc;
            if (m_own == 0) last_ld_data = lsu_ld_data;
        end
        @(posedge clk);
        hs_own = -1;
        if (!rst_n) begin
            m_busy = 0; m_starve = 0; m_err = 0;
        end else begin
            if (!m_busy && dm_rsp_valid) m_err = 1;
            if (expv && dm_req_ready) begin
                hs_own = sel; m_busy = 1; m_own = sel;
            end else if (m_busy && dm_rsp_valid) begin
                m_busy = 0;
            end
            if (!ext_req_valid || hs_own == 2) m_starve = 0;
            else if (m_starve < SMAX)          m_starve++;
        end
        if (hs_own >= 0) begin
            cd = lat; hs_cnt[hs_own]++; last_hs_cyc[hs_own] = cyc;
        end else if (cd > 0) begin
            cd--;
        end
        force_rsp = 0;
        #1;
        if (hs_own == 1 && !keep_st)  lsu_st_req_valid = 0;
        if (hs_own == 0 && !keep_ld)  lsu_ld_req_valid = 0;
        if (hs_own == 2 && !keep_ext) ext_req_valid = 0;
        cyc++;
    endtask

    initial begin
        int start, n, c0, r0;
        rst_n = 0; lsu_addr = '0; lsu_st_req_valid = 0; lsu_st_strb = 4'hF; lsu_st_data = '0;
        lsu_ld_req_valid = 1; ext_req_valid = 0; ext_req_we = 0; ext_addr = '0; ext_wdata = '0;
        ext_strb = 4'hF; dm_req_ready = 1; dm_rsp_valid = 0; dm_rdata = '0;
        @(posedge clk); #1;
        cycle(); cycle();
        rst_n = 1; lsu_ld_req_valid = 0;
        cycle();

        // Store drain with a 2-cycle memory.
        lat = 2; lsu_addr = 32'h100; lsu_st_strb = 4'b1110; lsu_st_data = 32'hA5A5_0011;
        lsu_st_req_valid = 1;
        cycle();
        chk("st_granted", hs_own, 1);
        cycle(); cycle(); cycle();
        chk("st_rsp_latency", last_rsp_cyc[1] - last_hs_cyc[1], 2);

        // Store and load together: store first, load issued in the response cycle.
        lat = 1; fix_rdata = 1; lsu_st_req_valid = 1; lsu_ld_req_valid = 1; lsu_addr = 32'h200;
        cycle();
        chk("store_wins", hs_own, 1);
        lsu_addr = 32'h204;
        cycle();
        chk("load_backtoback", hs_own, 0);
        cycle();
        chk("ld_deadbeef", last_ld_data, 32'hDEADBEEF);
        fix_rdata = 0;
        cycle();

        // External aging against a continuous store stream.
        keep_st = 1; lsu_st_req_valid = 1; ext_req_valid = 1; ext_req_we = 0; ext_addr = 32'h3000;
        start = cyc; n = 20;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (hs_own == 2) begin n = cyc - start; break; end
        end
        chk("ext_age_cycles", n, SMAX + 1);
        ext_req_valid = 1; ext_addr = 32'h3004;
        cycle();
        chk("ext_count_cleared", hs_own, 1);
        keep_st = 0; lsu_st_req_valid = 0;
        for (int i = 0; i < 4; i++) cycle();
        ext_req_valid = 0;
        cycle(); cycle();

        // Stream of four loads on a 1-cycle memory.
        lat = 1; keep_ld = 1; lsu_ld_req_valid = 1; c0 = hs_cnt[0]; r0 = rsp_cnt[0];
        for (int i = 0; i < 4; i++) begin
            lsu_addr = 32'h400 + 4 * i;
            cycle();
        end
        chk("ld_stream_hs", hs_cnt[0] - c0, 4);
        keep_ld = 0; lsu_ld_req_valid = 0;
        cycle(); cycle();
        chk("ld_stream_rsp", rsp_cnt[0] - r0, 4);

        // Spurious response while idle.
        force_rsp = 1;
        cycle(); cycle();
        chk("err_sticky", err_spurious_rsp, 1'b1);

        // Reset in the middle of an access.
        lat = 3; lsu_ld_req_valid = 1; lsu_addr = 32'h500;
        cycle();
        chk("ld_before_reset", hs_own, 0);
        lsu_ld_req_valid = 1; lsu_st_req_valid = 1; ext_req_valid = 1; rst_n = 0;
        #1;
        chk("rst_dm_valid", dm_req_valid, 1'b0);
        chk("rst_readies", {lsu_st_req_ready, lsu_ld_req_ready, ext_req_ready}, 3'b000);
        chk("rst_err_clear", err_spurious_rsp, 1'b0);
        cycle();
        lsu_ld_req_valid = 0; lsu_st_req_valid = 0; ext_req_valid = 0; rst_n = 1;
        cycle(); cycle(); cycle();
        chk("late_rsp_spurious", err_spurious_rsp, 1'b1);
        lat = 1; lsu_ld_req_valid = 1; lsu_addr = 32'h600;
        cycle();
        chk("ld_after_reset", hs_own, 0);
        cycle(); cycle();

        // Randomized traffic with memory stalls and variable latency.
        for (int i = 0; i < 500; i++) begin
            lat = $urandom_range(1, 3);
            dm_req_ready = ($urandom_range(0, 3) != 0);
            lsu_addr = $urandom;
            if (!lsu_st_req_valid) begin
                lsu_st_req_valid = ($urandom_range(0, 2) == 0);
                lsu_st_strb = 4'($urandom); lsu_st_data = $urandom;
            end
            if (!lsu_ld_req_valid) lsu_ld_req_valid = ($urandom_range(0, 2) == 0);
            if (!ext_req_valid) begin
                ext_req_valid = ($urandom_range(0, 2) == 0);
                ext_req_we = 1'($urandom); ext_addr = $urandom;
                ext_wdata = $urandom; ext_strb = 4'($urandom);
            end
            if (!m_busy && cd == 0 && $urandom_range(0, 49) == 0) force_rsp = 1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
